// File: rtl/ram1_uart_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline and ram1_uart_ctrl.
//   Req/We/Addr/WData : access request from the memory stage
//   RData/Ack/Busy    : load result, completion pulse, combinational stall
// master = memory stage, slave = controller.
interface ram1_uart_ctrl_if;
    logic        Req;
    logic        We;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic [15:0] RData;
    logic        Ack;
    logic        Busy;

    modport master (output Req, We, Addr, WData, input  RData, Ack, Busy);
    modport slave  (input  Req, We, Addr, WData, output RData, Ack, Busy);
endinterface

// File: rtl/ram1_uart_ctrl.sv
// Sequences memory-stage loads/stores onto the shared Ram1 SRAM / UART bus.
// Decodes the memory-mapped UART registers, orders the SRAM and UART strobes with
// a turnaround cycle, and stalls the pipeline via Busy until Ack.
// Ports:
//   Clk, Rst           : clock, synchronous active-high reset
//   memBus (slave)     : Req/We/Addr/WData in, RData/Ack/Busy out
//   data_ready/tbre/tsre : UART status inputs
//   rdn/wrn            : UART read/write strobes, active-low
//   Ram1_EN/OE/WE      : SRAM strobes, active-low
//   Ram1_address       : {2'b00, latched Addr}
//   Ram1_data          : shared bus, driven only during write phases
module ram1_uart_ctrl #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int unsigned WR_PULSE       = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    ram1_uart_ctrl_if.slave memBus,
    input  logic            data_ready,
    input  logic            tbre,
    input  logic            tsre,
    output logic            rdn,
    output logic            wrn,
    output logic            Ram1_EN,
    output logic            Ram1_OE,
    output logic            Ram1_WE,
    output logic [17:0]     Ram1_address,
    inout  wire  [15:0]     Ram1_data
);
    localparam int unsigned      CNT_W    = 3;
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] URD_LAST = CNT_W'(1);

    typedef enum logic [3:0] {IDLE, SRD, SWR, SWE, URD, UWR, UWE, STAT, DONE} ctrlState_t;

    ctrlState_t       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [15:0]      addrQ, addrNext;
    logic [15:0]      wDataQ, wDataNext;
    logic [15:0]      rData;
    logic             ack;
    logic             driveEn;
    logic [15:0]      driveData;

    logic             enNext, oeNext, weNext, rdnNext, wrnNext, driveEnNext;
    logic [15:0]      driveDataNext;

    // Next state, then strobe values for the state being entered so that the
    // registered strobes line up with the state register.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        addrNext      = addrQ;
        wDataNext     = wDataQ;
        enNext        = 1'b1;
        oeNext        = 1'b1;
        weNext        = 1'b1;
        rdnNext       = 1'b1;
        wrnNext       = 1'b1;
        driveEnNext   = 1'b0;
        driveDataNext = wDataQ;

        case (state)
            IDLE: begin
                if (memBus.Req) begin
                    addrNext  = memBus.Addr;
                    wDataNext = memBus.WData;
                    cntNext   = '0;
                    if (memBus.Addr == UART_DATA_ADDR) begin
                        stateNext = memBus.We ? UWR : URD;
                    end else if (memBus.Addr == UART_STAT_ADDR) begin
                        // Status register is read-only; a store just completes.
                        stateNext = memBus.We ? DONE : STAT;
                    end else begin
                        stateNext = memBus.We ? SWR : SRD;
                    end
                end
            end
            SRD:  stateNext = DONE;
            SWR: begin
                if (cnt == WR_LAST) begin
                    stateNext = SWE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            SWE:  stateNext = DONE;
            URD: begin
                if (cnt == URD_LAST) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            UWR: begin
                if (cnt == WR_LAST) begin
                    stateNext = UWE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            UWE:  stateNext = DONE;
            STAT: stateNext = DONE;
            DONE: stateNext = IDLE;
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase

        driveDataNext = wDataNext;
        case (stateNext)
            SRD: begin
                enNext = 1'b0;
                oeNext = 1'b0;
            end
            SWR: begin
                enNext      = 1'b0;
                weNext      = 1'b0;
                driveEnNext = 1'b1;
            end
            // Chip stays selected while write data is held past the WE rise.
            SWE: begin
                enNext      = 1'b0;
                driveEnNext = 1'b1;
            end
            URD: rdnNext = 1'b0;
            UWR: begin
                wrnNext       = 1'b0;
                driveEnNext   = 1'b1;
                driveDataNext = {8'h00, wDataNext[7:0]};
            end
            UWE: begin
                driveEnNext   = 1'b1;
                driveDataNext = {8'h00, wDataNext[7:0]};
            end
            default: ;
        endcase
    end

    // State, request latches and registered strobes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addrQ     <= '0;
            wDataQ    <= '0;
            ack       <= 1'b0;
            Ram1_EN   <= 1'b1;
            Ram1_OE   <= 1'b1;
            Ram1_WE   <= 1'b1;
            rdn       <= 1'b1;
            wrn       <= 1'b1;
            driveEn   <= 1'b0;
            driveData <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            addrQ     <= addrNext;
            wDataQ    <= wDataNext;
            ack       <= (stateNext == DONE);
            Ram1_EN   <= enNext;
            Ram1_OE   <= oeNext;
            Ram1_WE   <= weNext;
            rdn       <= rdnNext;
            wrn       <= wrnNext;
            driveEn   <= driveEnNext;
            driveData <= driveDataNext;
        end
    end

    // Load result capture at the end of the sampling cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rData <= '0;
        end else begin
            case (state)
                SRD:  rData <= Ram1_data;
                URD:  if (cnt == URD_LAST) rData <= {8'h00, Ram1_data[7:0]};
                STAT: rData <= {14'b0, data_ready, tbre & tsre};
                default: ;
            endcase
        end
    end

    assign memBus.RData = rData;
    assign memBus.Ack   = ack;
    assign memBus.Busy  = memBus.Req & ~ack;
    assign Ram1_address = {2'b00, addrQ};
    assign Ram1_data    = driveEn ? driveData : 16'hzzzz;

endmodule

// File: tb/tb_ram1_uart_ctrl.sv
// Self-checking bench for ram1_uart_ctrl: SRAM and UART bus models, a
// reference model of access latency / load results, directed and random tests.
`timescale 1ns/1ps
module tb_ram1_uart_ctrl;
    localparam int unsigned WR_PULSE       = 2;
    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
    localparam int          MAX_CYC        = 20;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        data_ready, tbre, tsre;
    logic        rdn, wrn, Ram1_EN, Ram1_OE, Ram1_WE;
    logic [17:0] Ram1_address;
    wire  [15:0] Ram1_data;

    ram1_uart_ctrl_if memBus();

    ram1_uart_ctrl #(
        .UART_DATA_ADDR(UART_DATA_ADDR),
        .UART_STAT_ADDR(UART_STAT_ADDR),
        .WR_PULSE      (WR_PULSE)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .memBus      (memBus),
        .data_ready  (data_ready),
        .tbre        (tbre),
        .tsre        (tsre),
        .rdn         (rdn),
        .wrn         (wrn),
        .Ram1_EN     (Ram1_EN),
        .Ram1_OE     (Ram1_OE),
        .Ram1_WE     (Ram1_WE),
        .Ram1_address(Ram1_address),
        .Ram1_data   (Ram1_data)
    );

    always #5 Clk = ~Clk;

    int unsigned cycAbs = 0;
    always @(posedge Clk) cycAbs <= cycAbs + 1;

    // SRAM chip and UART receive-register bus models
    logic [15:0] sramArr [0:65535];
    logic [15:0] uartRx;
    logic        tbDrive;
    logic [15:0] tbVal;
    assign tbDrive   = (!Ram1_EN && !Ram1_OE) || !rdn;
    assign tbVal     = !rdn ? uartRx : sramArr[Ram1_address[15:0]];
    assign Ram1_data = tbDrive ? tbVal : 16'hzzzz;
    always @(posedge Clk) if (!Ram1_EN && !Ram1_WE) sramArr[Ram1_address[15:0]] <= Ram1_data;

    // Reference model state
    logic [15:0] refMem [logic [15:0]];
    logic [15:0] refRData;

    int checks = 0;
    int fails  = 0;

    // Observations of the last access
    int          trAck, trAckAfter, trWeLow, trWeFirst, trOeLow, trEnLow;
    int          trRdnLow, trRdnFirst, trWrnLow, trWrnFirst, trDriven, trConflict, trBusyErr;
    int unsigned trEdge0Abs, trAckAbs;
    logic [15:0] trRData, trBusWr, trHoldVal;
    logic [17:0] trAddr;
    logic [4:0]  trIdleStrobes;
    bit          trIdleDriven, trDoneDriven;

    function automatic bit busDriven();
        return !tbDrive && (Ram1_data !== 16'h0000) && !$isunknown(Ram1_data);
    endfunction

    function automatic int expAckCycle(bit we, logic [15:0] a);
        if (a == UART_STAT_ADDR) return we ? 1 : 2;
        if (a == UART_DATA_ADDR) return we ? int'(WR_PULSE) + 2 : 3;
        return we ? int'(WR_PULSE) + 2 : 2;
    endfunction

    // Expected RData after an access, updating the reference state.
    function automatic logic [15:0] refAccess(bit we, logic [15:0] a, logic [15:0] d);
        if (a == UART_STAT_ADDR) begin
            if (!we) refRData = {14'b0, data_ready, tbre & tsre};
        end else if (a == UART_DATA_ADDR) begin
            if (!we) refRData = {8'h00, uartRx[7:0]};
        end else if (we) begin
            refMem[a] = d;
        end else begin
            refRData = refMem.exists(a) ? refMem[a] : 16'h0000;
        end
        return refRData;
    endfunction

    // Drive one access from the IDLE cycle and record what the bus did.
    task automatic runAccess(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             input bit dropReq, input bit keepReq);
        int expAck;
        bit reqLevel;
        bit driven;
        expAck = expAckCycle(we, addr);
        memBus.Req = 1'b1; memBus.We = we; memBus.Addr = addr; memBus.WData = wdata;
        trAck = 0; trAckAfter = 0; trWeLow = 0; trWeFirst = 0; trOeLow = 0; trEnLow = 0;
        trRdnLow = 0; trRdnFirst = 0; trWrnLow = 0; trWrnFirst = 0; trDriven = 0;
        trConflict = 0; trBusyErr = 0; trBusWr = 16'h0; trHoldVal = 16'h0; trAddr = '0;
        trDoneDriven = 1'b0; trRData = 16'h0; trAckAbs = 0;
        #1;
        if (memBus.Busy !== 1'b1) trBusyErr++;
        trIdleStrobes = {Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn};
        trIdleDriven  = busDriven();
        @(posedge Clk); #1;
        trEdge0Abs = cycAbs;
        reqLevel = 1'b1;
        if (dropReq) begin
            memBus.Req = 1'b0; memBus.We = ~we;
            memBus.Addr = 16'($urandom); memBus.WData = 16'($urandom);
            reqLevel = 1'b0;
        end
        #1;
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            if (cyc == 1) trAddr = Ram1_address;
            driven = busDriven();
            if (!Ram1_WE) begin trWeLow++; if (trWeFirst == 0) trWeFirst = cyc; end
            if (!Ram1_OE) trOeLow++;
            if (!Ram1_EN) trEnLow++;
            if (!rdn) begin trRdnLow++; if (trRdnFirst == 0) trRdnFirst = cyc; end
            if (!wrn) begin trWrnLow++; if (trWrnFirst == 0) trWrnFirst = cyc; end
            if (driven) begin
                trDriven++;
                if (!Ram1_WE || !wrn) trBusWr = Ram1_data;
                else trHoldVal = Ram1_data;
            end
            if (!Ram1_EN && (!rdn || !wrn)) trConflict++;
            if (memBus.Busy !== (reqLevel && (cyc != expAck))) trBusyErr++;
            if (memBus.Ack === 1'b1) begin
                trAck = cyc; trRData = memBus.RData; trDoneDriven = driven; trAckAbs = cycAbs;
                break;
            end
            @(posedge Clk); #2;
        end
        @(posedge Clk); #1;
        trAckAfter = int'(memBus.Ack);
        if (!keepReq) memBus.Req = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        memBus.Req = 1'b1; memBus.We = 1'b1; memBus.Addr = 16'h0042; memBus.WData = 16'h1111;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (memBus.Ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", memBus.Ack); end
        checks++; if (memBus.RData !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0000", memBus.RData); end
        checks++; if ({Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn} !== 5'b11111) begin
            fails++; $display("FAIL reset_strobes: got %b want 11111", {Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn}); end
        checks++; if (busDriven()) begin fails++; $display("FAIL reset_bus: got driven %h want Z", Ram1_data); end
        checks++; if (memBus.Busy !== 1'b1) begin fails++; $display("FAIL reset_busy_req1: got %b want 1", memBus.Busy); end
        memBus.Req = 1'b0; #1;
        checks++; if (memBus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy_req0: got %b want 0", memBus.Busy); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        refRData = 16'h0;
        @(posedge Clk); #1;
    endtask

    task automatic test_sram_store_load();
        logic [15:0] exp;
        exp = refAccess(1'b1, 16'h0123, 16'hBEEF);
        runAccess(1'b1, 16'h0123, 16'hBEEF, 1'b0, 1'b0);
        checks++; if (trAck !== expAckCycle(1'b1, 16'h0123)) begin fails++; $display("FAIL sram_store_ack: got cycle %0d want %0d", trAck, expAckCycle(1'b1, 16'h0123)); end
        checks++; if (trWeLow !== int'(WR_PULSE) || trWeFirst !== 1) begin fails++; $display("FAIL sram_store_we: got %0d cycles from %0d want %0d from 1", trWeLow, trWeFirst, WR_PULSE); end
        checks++; if (trBusWr !== 16'hBEEF || trHoldVal !== 16'hBEEF || trDriven !== int'(WR_PULSE) + 1) begin
            fails++; $display("FAIL sram_store_bus: got %h/%h %0d cycles want BEEF/BEEF %0d", trBusWr, trHoldVal, trDriven, WR_PULSE + 1); end
        checks++; if (trAddr !== 18'h00123) begin fails++; $display("FAIL sram_store_addr: got %h want 00123", trAddr); end
        checks++; if (trRData !== exp) begin fails++; $display("FAIL sram_store_rdata_kept: got %h want %h", trRData, exp); end
        checks++; if (trAckAfter !== 0 || trBusyErr !== 0 || trRdnLow + trWrnLow !== 0) begin
            fails++; $display("FAIL sram_store_misc: ackAfter %0d busyErr %0d uartStrobes %0d want 0 0 0", trAckAfter, trBusyErr, trRdnLow + trWrnLow); end
        exp = refAccess(1'b0, 16'h0123, 16'h0);
        runAccess(1'b0, 16'h0123, 16'h0, 1'b0, 1'b0);
        checks++; if (trAck !== 2) begin fails++; $display("FAIL sram_load_ack: got cycle %0d want 2", trAck); end
        checks++; if (trRData !== 16'hBEEF || exp !== 16'hBEEF) begin fails++; $display("FAIL sram_load_rdata: got %h want BEEF", trRData); end
        checks++; if (trOeLow !== 1 || trEnLow !== 1 || trDriven !== 0) begin
            fails++; $display("FAIL sram_load_strobes: got oe %0d en %0d driven %0d want 1 1 0", trOeLow, trEnLow, trDriven); end
        checks++; if (trAddr !== 18'h00123) begin fails++; $display("FAIL sram_load_addr: got %h want 00123", trAddr); end
    endtask

    task automatic test_uart_store();
        void'(refAccess(1'b1, UART_DATA_ADDR, 16'h1241));
        runAccess(1'b1, UART_DATA_ADDR, 16'h1241, 1'b0, 1'b0);
        checks++; if (trAck !== int'(WR_PULSE) + 2) begin fails++; $display("FAIL uart_store_ack: got cycle %0d want %0d", trAck, WR_PULSE + 2); end
        checks++; if (trWrnLow !== int'(WR_PULSE) || trWrnFirst !== 1) begin fails++; $display("FAIL uart_store_wrn: got %0d from %0d want %0d from 1", trWrnLow, trWrnFirst, WR_PULSE); end
        checks++; if (trBusWr !== 16'h0041 || trHoldVal !== 16'h0041) begin fails++; $display("FAIL uart_store_bus: got %h/%h want 0041", trBusWr, trHoldVal); end
        checks++; if (trEnLow !== 0 || trWeLow !== 0 || trConflict !== 0) begin fails++; $display("FAIL uart_store_sram_idle: got en %0d we %0d want 0 0", trEnLow, trWeLow); end
    endtask

    task automatic test_uart_load();
        logic [15:0] exp;
        uartRx = 16'hFF5A;
        exp = refAccess(1'b0, UART_DATA_ADDR, 16'h0);
        runAccess(1'b0, UART_DATA_ADDR, 16'h0, 1'b0, 1'b0);
        checks++; if (trAck !== 3) begin fails++; $display("FAIL uart_load_ack: got cycle %0d want 3", trAck); end
        checks++; if (trRData !== 16'h005A || exp !== 16'h005A) begin fails++; $display("FAIL uart_load_rdata: got %h want 005A", trRData); end
        checks++; if (trRdnLow !== 2 || trRdnFirst !== 1 || trEnLow !== 0 || trDriven !== 0) begin
            fails++; $display("FAIL uart_load_strobes: got rdn %0d from %0d en %0d driven %0d want 2 1 0 0", trRdnLow, trRdnFirst, trEnLow, trDriven); end
    endtask

    task automatic test_status();
        logic [15:0] exp;
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        exp = refAccess(1'b0, UART_STAT_ADDR, 16'h0);
        runAccess(1'b0, UART_STAT_ADDR, 16'h0, 1'b0, 1'b0);
        checks++; if (trAck !== 2) begin fails++; $display("FAIL stat_load_ack: got cycle %0d want 2", trAck); end
        checks++; if (trRData !== 16'h0002 || exp !== 16'h0002) begin fails++; $display("FAIL stat_load_rdata: got %h want 0002", trRData); end
        checks++; if (trWeLow + trOeLow + trEnLow + trRdnLow + trWrnLow + trDriven !== 0) begin
            fails++; $display("FAIL stat_load_strobes: got %0d strobe cycles want 0", trWeLow + trOeLow + trEnLow + trRdnLow + trWrnLow + trDriven); end
        exp = refAccess(1'b1, UART_STAT_ADDR, 16'h7777);
        runAccess(1'b1, UART_STAT_ADDR, 16'h7777, 1'b0, 1'b0);
        checks++; if (trAck !== 1 || trRData !== exp) begin fails++; $display("FAIL stat_store: got ack %0d rdata %h want 1 %h", trAck, trRData, exp); end
    endtask

    task automatic test_back_to_back();
        int unsigned firstEdge0;
        logic [15:0] exp;
        exp = refAccess(1'b0, 16'h0123, 16'h0);
        runAccess(1'b0, 16'h0123, 16'h0, 1'b0, 1'b1);
        firstEdge0 = trEdge0Abs;
        checks++; if (trRData !== exp || trDoneDriven) begin fails++; $display("FAIL b2b_load: got %h doneDriven %b want %h 0", trRData, trDoneDriven, exp); end
        void'(refAccess(1'b1, UART_DATA_ADDR, 16'h33C7));
        runAccess(1'b1, UART_DATA_ADDR, 16'h33C7, 1'b0, 1'b0);
        checks++; if (trIdleStrobes !== 5'b11111 || trIdleDriven) begin
            fails++; $display("FAIL b2b_gap: got strobes %b driven %b want 11111 0", trIdleStrobes, trIdleDriven); end
        checks++; if (trAckAbs - firstEdge0 !== WR_PULSE + 4) begin
            fails++; $display("FAIL b2b_total: got %0d cycles want %0d", trAckAbs - firstEdge0, WR_PULSE + 4); end
        checks++; if (trWrnFirst !== 1 || trBusWr !== 16'h00C7 || trConflict !== 0 || trBusyErr !== 0) begin
            fails++; $display("FAIL b2b_store: got wrnFirst %0d bus %h conflict %0d busyErr %0d want 1 00C7 0 0", trWrnFirst, trBusWr, trConflict, trBusyErr); end
    endtask

    task automatic test_reset_mid_swr();
        int ackSeen;
        memBus.Req = 1'b1; memBus.We = 1'b1; memBus.Addr = 16'h7777; memBus.WData = 16'h1357;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checks++; if (Ram1_WE !== 1'b0) begin fails++; $display("FAIL rst_swr_pre: got WE %b want 0", Ram1_WE); end
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks++; if ({Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn} !== 5'b11111 || busDriven() || memBus.Ack !== 1'b0) begin
            fails++; $display("FAIL rst_swr_release: got strobes %b bus %h ack %b want 11111 Z 0", {Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn}, Ram1_data, memBus.Ack); end
        Rst = 1'b0; memBus.Req = 1'b0;
        refRData = 16'h0;
        ackSeen = 0;
        repeat (5) begin @(posedge Clk); #1; if (memBus.Ack === 1'b1) ackSeen++; end
        checks++; if (ackSeen !== 0) begin fails++; $display("FAIL rst_swr_no_ack: got %0d ack cycles want 0", ackSeen); end
        void'(refAccess(1'b0, UART_STAT_ADDR, 16'h0));
        runAccess(1'b0, UART_STAT_ADDR, 16'h0, 1'b0, 1'b0);
        checks++; if (trAck !== 2 || trRData !== refRData) begin fails++; $display("FAIL rst_swr_after: got ack %0d rdata %h want 2 %h", trAck, trRData, refRData); end
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        logic [15:0] addr, wdata, exp;
        bit          we, drop;
        int          kind, expStrobe, gotStrobe, expDrv;
        for (int i = 0; i < 8; i++) pool[i] = 16'($urandom_range(16'h1000, 16'h1FFF));
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 9);
            we    = 1'($urandom);
            drop  = ($urandom_range(0, 3) == 0);
            wdata = 16'($urandom) | 16'h0001;
            uartRx = 16'($urandom);
            data_ready = 1'($urandom); tbre = 1'($urandom); tsre = 1'($urandom);
            addr = (kind < 6) ? pool[$urandom_range(0, 7)] : ((kind < 8) ? UART_DATA_ADDR : UART_STAT_ADDR);
            exp = refAccess(we, addr, wdata);
            runAccess(we, addr, wdata, drop, 1'b0);
            checks++; if (trAck !== expAckCycle(we, addr)) begin
                fails++; $display("FAIL rand%0d_ack: addr %h we %b got cycle %0d want %0d", n, addr, we, trAck, expAckCycle(we, addr)); end
            checks++; if (trRData !== exp) begin fails++; $display("FAIL rand%0d_rdata: addr %h we %b got %h want %h", n, addr, we, trRData, exp); end
            // {we, oe, rdn, wrn} low-cycle counts packed one nibble each
            gotStrobe = (trWeLow << 12) | (trOeLow << 8) | (trRdnLow << 4) | trWrnLow;
            if (kind < 6) expStrobe = we ? (int'(WR_PULSE) << 12) : (1 << 8);
            else if (kind < 8) expStrobe = we ? int'(WR_PULSE) : (2 << 4);
            else expStrobe = 0;
            checks++; if (gotStrobe !== expStrobe) begin fails++; $display("FAIL rand%0d_strobes: addr %h we %b got %h want %h", n, addr, we, gotStrobe, expStrobe); end
            expDrv = (we && kind < 8) ? int'(WR_PULSE) + 1 : 0;
            checks++; if (trDriven !== expDrv || trConflict !== 0 || trDoneDriven || trBusyErr !== 0 || trAckAfter !== 0) begin
                fails++; $display("FAIL rand%0d_bus: driven %0d conflict %0d done %b busyErr %0d ackAfter %0d want %0d 0 0 0 0", n, trDriven, trConflict, trDoneDriven, trBusyErr, trAckAfter, expDrv); end
            if (we && kind < 8) begin
                checks++; if (trBusWr !== ((kind < 6) ? wdata : {8'h00, wdata[7:0]})) begin
                    fails++; $display("FAIL rand%0d_wdata: got %h want %h", n, trBusWr, (kind < 6) ? wdata : {8'h00, wdata[7:0]}); end
            end
            if (kind < 6) begin
                checks++; if (trAddr !== {2'b00, addr}) begin fails++; $display("FAIL rand%0d_addr: got %h want %h", n, trAddr, {2'b00, addr}); end
            end else begin
                checks++; if (trEnLow !== 0) begin fails++; $display("FAIL rand%0d_en: got %0d cycles want 0", n, trEnLow); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sramArr[i] = 16'h0000;
        Rst = 1'b1;
        memBus.Req = 1'b0; memBus.We = 1'b0; memBus.Addr = 16'h0; memBus.WData = 16'h0;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; uartRx = 16'h0;
        refRData = 16'h0;
        test_reset();
        test_sram_store_load();
        test_uart_store();
        test_uart_load();
        test_status();
        test_back_to_back();
        test_reset_mid_swr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
